// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the sub-word MIPS data memory.
// Size and FSM encodings, lane count, alignment and lane-mask helpers.
package data_mem_pkg;

  localparam int DATA_W = 32;
  localparam int LANES  = DATA_W / 8;

  // Encoding 2'b11 is reserved and decodes as a word everywhere.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    if (size == SZ_BYTE)      return 1'b0;
    else if (size == SZ_HALF) return off[0];
    else                      return (off != 2'b00);
  endfunction

  // Byte-enable mask of the lanes touched by an access of this size and offset.
  function automatic logic [LANES-1:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    if (size == SZ_BYTE)      return LANES'(1) << off;
    else if (size == SZ_HALF) return off[1] ? 4'b1100 : 4'b0011;
    else                      return {LANES{1'b1}};
  endfunction

endpackage

// File: rtl/dmem_load_extend.sv
// Load aligner: picks the addressed byte/half out of a 32-bit word,
// right-justifies it and sign- or zero-extends it.
module dmem_load_extend
  import data_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        fill;

  // NOTE: every signal written in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? word[31:16] : word[15:0];
    fill     = 1'b0;
    result   = word;
    if (size == SZ_BYTE) begin
      fill   = ~is_unsigned & byte_sel[7];
      result = {{24{fill}}, byte_sel};
    end else if (size == SZ_HALF) begin
      fill   = ~is_unsigned & half_sel[15];
      result = {{16{fill}}, half_sel};
    end
  end

endmodule

// File: rtl/data_mem_subword.sv
// MIPS data memory with lb/lbu/lh/lhu/lw/sb/sh/sw, LATENCY-cycle access and
// valid/ready handshake. Optional misalignment trap: DMEM_ALIGN_CHECK_EN.
module data_mem_subword
  import data_mem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 1   // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int               DEPTH    = 1 << (ADDR_W - 2);
  localparam int               CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              ready_q;

  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              access;
  logic              misalign;
  logic [1:0]        eff_off;
  logic [ADDR_W-3:0] word_idx;
  logic [31:0]       rd_word;
  logic [31:0]       ld_data;
  logic [LANES-1:0]  wmask;
  logic [31:0]       wr_lanes;
  logic [31:0]       merged;

  assign accept    = req_valid & ready_q;
  assign access    = (state == ST_BUSY) && (cnt == '0);
  assign req_ready = ready_q;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = is_misaligned(size_q, addr_q[1:0]);
  assign eff_off  = addr_q[1:0];
`else
  // Without the trap, offending low address bits are simply ignored.
  assign misalign = 1'b0;
  always_comb begin
    eff_off = 2'b00;
    if (size_q == SZ_BYTE)      eff_off = addr_q[1:0];
    else if (size_q == SZ_HALF) eff_off = {addr_q[1], 1'b0};
  end
`endif

  assign word_idx = addr_q[ADDR_W-1:2];
  assign rd_word  = mem[word_idx];

  dmem_load_extend u_load_extend (
    .word        (rd_word),
    .offset      (eff_off),
    .size        (size_q),
    .is_unsigned (uns_q),
    .result      (ld_data)
  );

  // Store lane merge: replicate the right-justified data into every lane,
  // then take only the enabled lanes over the current word.
  always_comb begin
    wmask    = lane_mask(size_q, eff_off);
    wr_lanes = wdata_q;
    if (size_q == SZ_BYTE)      wr_lanes = {4{wdata_q[7:0]}};
    else if (size_q == SZ_HALF) wr_lanes = {2{wdata_q[15:0]}};
    for (int i = 0; i < LANES; i++) begin
      merged[8*i +: 8] = wmask[i] ? wr_lanes[8*i +: 8] : rd_word[8*i +: 8];
    end
  end

  // A new request may be taken in IDLE or in the RESP cycle.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = ST_BUSY;
      ST_BUSY: if (cnt == '0) state_nx = ST_RESP;
      ST_RESP: state_nx = accept ? ST_BUSY : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      ready_q    <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      ready_q    <= (state_nx != ST_BUSY);
      resp_valid <= access;
      if (accept)                               cnt <= CNT_LOAD;
      else if (state == ST_BUSY && cnt != '0)   cnt <= cnt - 1'b1;
      if (access) begin
        resp_rdata <= (we_q || misalign) ? 32'h0 : ld_data;
        resp_err   <= misalign;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // NOTE: the array has no reset so it maps onto RAM; an aborted store never
  // writes because reset forces the FSM out of BUSY before the access edge.
  always_ff @(posedge clk) begin
    if (access && we_q && !misalign) mem[word_idx] <= merged;
  end

endmodule

// File: tb/tb_data_mem_subword.sv
// Directed bench for data_mem_subword at LATENCY=2; expectations follow
// whether DMEM_ALIGN_CHECK_EN is defined for the build.
module tb_data_mem_subword;
  import data_mem_pkg::*;

  localparam int ADDR_W  = 8;
  localparam int LATENCY = 2;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  int checks = 0;
  int errors = 0;

  data_mem_subword #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request: drive at a falling edge, wait for ready, count rising edges
  // from accept to resp_valid, then check latency, data, error and pulse width.
  task automatic xfer(input string tag, input logic we, input logic [1:0] sz,
                      input logic uns, input logic [7:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
    int n;
    @(negedge clk);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " ready"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs after accept: the DUT must use its captured copy.
    req_valid = 1'b0; req_we = ~we; req_size = ~sz; req_unsigned = ~uns;
    req_addr = ~a; req_wdata = ~wd;
    n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(LATENCY));
    check({tag, " rdata"}, resp_rdata, exp_rd);
    check({tag, " err"}, {31'b0, resp_err}, {31'b0, exp_err});
    @(negedge clk);
    check({tag, " pulse"}, {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] exp_w08;
    logic        exp_mis_err;
    logic [31:0] exp_mis_lw;
    int          edge_n, first_acc, second_acc;
    logic        acc, saw_resp;

`ifdef DMEM_ALIGN_CHECK_EN
    exp_mis_err = 1'b1;
    exp_mis_lw  = 32'h0000_0000;
    exp_w08     = 32'h87FF_8001;
`else
    exp_mis_err = 1'b0;
    exp_mis_lw  = 32'h87FF_8001;
    exp_w08     = 32'hDEAD_BEEF;
`endif

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

    // Reset behaviour
    repeat (3) @(negedge clk);
    check("rst ready", {31'b0, req_ready}, 32'd0);
    check("rst resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-rst ready", {31'b0, req_ready}, 32'd1);

    // Word store and load
    xfer("sw 08", 1'b1, SZ_WORD, 1'b0, 8'h08, 32'h8765_4321, 32'h0, 1'b0);
    xfer("lw 08", 1'b0, SZ_WORD, 1'b0, 8'h08, 32'h0, 32'h8765_4321, 1'b0);

    // Byte store and loads
    xfer("sb 0A", 1'b1, SZ_BYTE, 1'b0, 8'h0A, 32'h0000_00FF, 32'h0, 1'b0);
    xfer("lw 08 b", 1'b0, SZ_WORD, 1'b0, 8'h08, 32'h0, 32'h87FF_4321, 1'b0);
    xfer("lb 0A", 1'b0, SZ_BYTE, 1'b0, 8'h0A, 32'h0, 32'hFFFF_FFFF, 1'b0);
    xfer("lbu 0A", 1'b0, SZ_BYTE, 1'b1, 8'h0A, 32'h0, 32'h0000_00FF, 1'b0);

    // Halfword store (upper wdata bits must be ignored) and loads
    xfer("sh 08", 1'b1, SZ_HALF, 1'b0, 8'h08, 32'hABCD_8001, 32'h0, 1'b0);
    xfer("lh 08", 1'b0, SZ_HALF, 1'b0, 8'h08, 32'h0, 32'hFFFF_8001, 1'b0);
    xfer("lhu 08", 1'b0, SZ_HALF, 1'b1, 8'h08, 32'h0, 32'h0000_8001, 1'b0);
    xfer("lw 08 h", 1'b0, SZ_WORD, 1'b0, 8'h08, 32'h0, 32'h87FF_8001, 1'b0);

    // Remaining lanes of word 0x08 = 87 FF 80 01
    xfer("lb 09", 1'b0, SZ_BYTE, 1'b0, 8'h09, 32'h0, 32'hFFFF_FF80, 1'b0);
    xfer("lbu 09", 1'b0, SZ_BYTE, 1'b1, 8'h09, 32'h0, 32'h0000_0080, 1'b0);
    xfer("lb 0B", 1'b0, SZ_BYTE, 1'b0, 8'h0B, 32'h0, 32'hFFFF_FF87, 1'b0);
    xfer("lh 0A", 1'b0, SZ_HALF, 1'b0, 8'h0A, 32'h0, 32'hFFFF_87FF, 1'b0);
    xfer("lhu 0A", 1'b0, SZ_HALF, 1'b1, 8'h0A, 32'h0, 32'h0000_87FF, 1'b0);
    xfer("lw rsvd", 1'b0, 2'b11, 1'b1, 8'h08, 32'h0, 32'h87FF_8001, 1'b0);

    // Misaligned accesses
    xfer("lw 09", 1'b0, SZ_WORD, 1'b0, 8'h09, 32'h0, exp_mis_lw, exp_mis_err);
    xfer("sw 09", 1'b1, SZ_WORD, 1'b0, 8'h09, 32'hDEAD_BEEF, 32'h0, exp_mis_err);
    xfer("lw 08 m", 1'b0, SZ_WORD, 1'b0, 8'h08, 32'h0, exp_w08, 1'b0);

    // Back-to-back: req_valid held high, accepts spaced LATENCY+1 edges
    @(negedge clk);
    req_we = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0; req_addr = 8'h08;
    req_wdata = 32'h0; req_valid = 1'b1;
    edge_n = 0; first_acc = -1; second_acc = -1;
    for (int i = 0; i < 10; i++) begin
      acc = req_ready;
      @(posedge clk);
      edge_n++;
      if (acc) begin
        if (first_acc < 0)       first_acc  = edge_n;
        else if (second_acc < 0) second_acc = edge_n;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("b2b spacing", 32'(second_acc - first_acc), 32'(LATENCY + 1));
    repeat (LATENCY + 2) @(negedge clk);
    check("b2b rdata hold", resp_rdata, exp_w08);

    // Reset abort of a pending store
    xfer("sw 10", 1'b1, SZ_WORD, 1'b0, 8'h10, 32'h1122_3344, 32'h0, 1'b0);
    @(negedge clk);
    req_we = 1'b1; req_size = SZ_WORD; req_unsigned = 1'b0; req_addr = 8'h10;
    req_wdata = 32'h5A5A_5A5A; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    saw_resp = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid) saw_resp = 1'b1;
    end
    check("abort rst ready", {31'b0, req_ready}, 32'd0);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) saw_resp = 1'b1;
    end
    check("abort no resp", {31'b0, saw_resp}, 32'd0);
    xfer("lw 10", 1'b0, SZ_WORD, 1'b0, 8'h10, 32'h0, 32'h1122_3344, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
